// File: rtl/preamble_pkg.sv
// Shared constants and types for the 802.11a transmit preamble source.
package preamble_pkg;

  localparam int STS_LEN   = 16;
  localparam int STS_REPS  = 10;
  localparam int LTS_LEN   = 64;
  localparam int LTS_REPS  = 2;
  localparam int GI2_LEN   = 32;
  localparam int TOTAL_LEN = STS_LEN * STS_REPS + GI2_LEN + LTS_LEN * LTS_REPS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STS  = 2'd1,
    GI2  = 2'd2,
    LTS  = 2'd3
  } state_t;

  typedef enum logic {
    TBL_STS = 1'b0,
    TBL_LTS = 1'b1
  } tbl_sel_t;

  // 2'b10 is deliberately unused so the sample alphabet stays symmetric.
  localparam logic [1:0] Q_ZERO = 2'b00;
  localparam logic [1:0] Q_POS  = 2'b01;
  localparam logic [1:0] Q_NEG  = 2'b11;

endpackage

// File: rtl/preamble_rom.sv
// Sign-quantized short/long training symbol tables, same source as the RX
// long-sync correlator weights; entries are packed as {I, Q}.
module preamble_rom
  import preamble_pkg::*;
(
  input  tbl_sel_t   tbl_sel,
  input  logic [5:0] addr,
  output logic [1:0] i_val,
  output logic [1:0] q_val
);

  localparam logic [3:0] PP = {Q_POS,  Q_POS};
  localparam logic [3:0] PZ = {Q_POS,  Q_ZERO};
  localparam logic [3:0] PN = {Q_POS,  Q_NEG};
  localparam logic [3:0] ZP = {Q_ZERO, Q_POS};
  localparam logic [3:0] ZN = {Q_ZERO, Q_NEG};
  localparam logic [3:0] NP = {Q_NEG,  Q_POS};
  localparam logic [3:0] NZ = {Q_NEG,  Q_ZERO};
  localparam logic [3:0] NN = {Q_NEG,  Q_NEG};

  logic [3:0] sts_iq;
  logic [3:0] lts_iq;

  always_comb begin
    sts_iq = {Q_ZERO, Q_ZERO};
    case (addr[3:0])
      4'd0:  sts_iq = PP;  4'd1:  sts_iq = NZ;  4'd2:  sts_iq = ZN;  4'd3:  sts_iq = PZ;
      4'd4:  sts_iq = PZ;  4'd5:  sts_iq = PZ;  4'd6:  sts_iq = ZN;  4'd7:  sts_iq = NZ;
      4'd8:  sts_iq = PP;  4'd9:  sts_iq = ZN;  4'd10: sts_iq = NZ;  4'd11: sts_iq = ZP;
      4'd12: sts_iq = ZP;  4'd13: sts_iq = ZP;  4'd14: sts_iq = NZ;  4'd15: sts_iq = ZN;
      default: sts_iq = {Q_ZERO, Q_ZERO};
    endcase
  end

  always_comb begin
    lts_iq = {Q_ZERO, Q_ZERO};
    case (addr)
      6'd0:  lts_iq = PZ;  6'd1:  lts_iq = ZN;  6'd2:  lts_iq = PN;  6'd3:  lts_iq = PP;
      6'd4:  lts_iq = PP;  6'd5:  lts_iq = PN;  6'd6:  lts_iq = NN;  6'd7:  lts_iq = NN;
      6'd8:  lts_iq = PN;  6'd9:  lts_iq = PZ;  6'd10: lts_iq = ZN;  6'd11: lts_iq = NN;
      6'd12: lts_iq = PN;  6'd13: lts_iq = PZ;  6'd14: lts_iq = NP;  6'd15: lts_iq = PZ;
      6'd16: lts_iq = PP;  6'd17: lts_iq = PN;  6'd18: lts_iq = NN;  6'd19: lts_iq = NP;
      6'd20: lts_iq = PP;  6'd21: lts_iq = PZ;  6'd22: lts_iq = NP;  6'd23: lts_iq = NN;
      6'd24: lts_iq = NN;  6'd25: lts_iq = NZ;  6'd26: lts_iq = NN;  6'd27: lts_iq = PN;
      6'd28: lts_iq = ZP;  6'd29: lts_iq = NP;  6'd30: lts_iq = PP;  6'd31: lts_iq = ZP;
      6'd32: lts_iq = NZ;  6'd33: lts_iq = ZN;  6'd34: lts_iq = PN;  6'd35: lts_iq = NN;
      6'd36: lts_iq = ZN;  6'd37: lts_iq = PP;  6'd38: lts_iq = NP;  6'd39: lts_iq = NZ;
      6'd40: lts_iq = NP;  6'd41: lts_iq = NP;  6'd42: lts_iq = NN;  6'd43: lts_iq = PZ;
      6'd44: lts_iq = PN;  6'd45: lts_iq = NN;  6'd46: lts_iq = NP;  6'd47: lts_iq = PP;
      6'd48: lts_iq = PN;  6'd49: lts_iq = PZ;  6'd50: lts_iq = NN;  6'd51: lts_iq = PZ;
      6'd52: lts_iq = PP;  6'd53: lts_iq = NP;  6'd54: lts_iq = ZP;  6'd55: lts_iq = PZ;
      6'd56: lts_iq = PP;  6'd57: lts_iq = NP;  6'd58: lts_iq = NP;  6'd59: lts_iq = PP;
      6'd60: lts_iq = PN;  6'd61: lts_iq = PN;  6'd62: lts_iq = PP;  6'd63: lts_iq = ZP;
      default: lts_iq = {Q_ZERO, Q_ZERO};
    endcase
  end

  assign i_val = (tbl_sel == TBL_LTS) ? lts_iq[3:2] : sts_iq[3:2];
  assign q_val = (tbl_sel == TBL_LTS) ? lts_iq[1:0] : sts_iq[1:0];

endmodule

// File: rtl/preamble_tx_gen.sv
// 802.11a preamble source: 10 STS, GI2, 2 LTS as 2-bit I/Q samples, one per
// sample_tick, driven one cycle after the tick.
module preamble_tx_gen
  import preamble_pkg::*;
(
  input  logic       CLK,
  input  logic       s_RST,
  input  logic       start,
  input  logic       abort,
  input  logic       sample_tick,
  output logic [1:0] I_out,
  output logic [1:0] Q_out,
  output logic       output_strobe,
  output logic       lts_start,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] STS_LAST = 8'(STS_LEN * STS_REPS - 1);
  localparam logic [7:0] GI2_LAST = 8'(GI2_LEN - 1);
  localparam logic [7:0] LTS_LAST = 8'(TOTAL_LEN - STS_LEN * STS_REPS - GI2_LEN - 1);
  localparam logic [5:0] GI2_BASE = 6'(LTS_LEN - GI2_LEN);

  state_t     state;
  state_t     next_state;
  logic [7:0] samp_cnt;
  logic       phase_end;
  tbl_sel_t   rom_sel;
  logic [5:0] rom_addr;
  logic [1:0] rom_i;
  logic [1:0] rom_q;

  // GI2 replays the tail half of the long symbol, so it reads the LTS table.
  always_comb begin
    rom_sel    = TBL_STS;
    rom_addr   = {2'b00, samp_cnt[3:0]};
    phase_end  = 1'b0;
    next_state = state;
    case (state)
      STS: begin
        phase_end  = (samp_cnt == STS_LAST);
        next_state = GI2;
      end
      GI2: begin
        rom_sel    = TBL_LTS;
        rom_addr   = GI2_BASE + samp_cnt[5:0];
        phase_end  = (samp_cnt == GI2_LAST);
        next_state = LTS;
      end
      LTS: begin
        rom_sel    = TBL_LTS;
        rom_addr   = samp_cnt[5:0];
        phase_end  = (samp_cnt == LTS_LAST);
        next_state = IDLE;
      end
      default: ;
    endcase
  end

  preamble_rom u_rom (
    .tbl_sel (rom_sel),
    .addr    (rom_addr),
    .i_val   (rom_i),
    .q_val   (rom_q)
  );

  always_ff @(posedge CLK) begin
    if (s_RST) begin
      state         <= IDLE;
      samp_cnt      <= '0;
      I_out         <= Q_ZERO;
      Q_out         <= Q_ZERO;
      output_strobe <= 1'b0;
      lts_start     <= 1'b0;
      done          <= 1'b0;
    end else begin
      output_strobe <= 1'b0;
      lts_start     <= 1'b0;
      done          <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= STS;
            samp_cnt <= '0;
          end
        end
        default: begin
          // abort wins over a tick in the same cycle
          if (abort) begin
            state    <= IDLE;
            samp_cnt <= '0;
            I_out    <= Q_ZERO;
            Q_out    <= Q_ZERO;
          end else if (sample_tick) begin
            I_out         <= rom_i;
            Q_out         <= rom_q;
            output_strobe <= 1'b1;
            lts_start     <= (state == LTS) && (samp_cnt == 8'd0);
            if (phase_end) begin
              state    <= next_state;
              samp_cnt <= '0;
              done     <= (state == LTS);
            end else begin
              samp_cnt <= samp_cnt + 8'd1;
            end
          end
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
